// File: rtl/mario_sound_mixer.sv
// mario_sound_mixer
//   Final audio stage. Samples the digital and analog/sample sound streams once per
//   sample tick, mixes them with saturation, removes DC with a first-order high-pass,
//   and applies a master gain that ramps one step per tick for pop-free mute/unmute.
//
// Ports
//   I_CLK_24M  in   system clock, single clock domain
//   I_RSTn     in   asynchronous active-low reset
//   I_SND_DIG  in   signed 16-bit digital sound
//   I_SND_ANA  in   signed 16-bit analog/sample sound
//   I_VOL      in   gain target 0..16 (values above 16 clamp to 16), 16 = unity
//   I_MUTE     in   forces the gain target to 0
//   I_DCB_EN   in   DC blocker enable (0 = bypass, stage still registered)
//   O_SND_OUT  out  signed 16-bit mixed output, held between strobes
//   O_SND_STB  out  one-clock pulse when O_SND_OUT updates
//   O_MUTED    out  high while the current gain is 0
module mario_sound_mixer #(
  parameter int unsigned DIV       = 500,
  parameter int unsigned DIG_SHIFT = 0,
  parameter int unsigned ANA_SHIFT = 0,
  parameter int unsigned DCB_K     = 8
) (
  input  logic               I_CLK_24M,
  input  logic               I_RSTn,
  input  logic signed [15:0] I_SND_DIG,
  input  logic signed [15:0] I_SND_ANA,
  input  logic        [4:0]  I_VOL,
  input  logic               I_MUTE,
  input  logic               I_DCB_EN,
  output logic signed [15:0] O_SND_OUT,
  output logic               O_SND_STB,
  output logic               O_MUTED
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  // Clip a sign-extended 21-bit value to 16 bits: in range when bits [20:15] agree.
  function automatic logic signed [15:0] sat16(input logic signed [20:0] v);
    if (v[20:15] == '0 || v[20:15] == '1) return v[15:0];
    else if (v[20])                        return 16'sh8000;
    else                                   return 16'sh7fff;
  endfunction

  // Sample tick
  logic [CW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == CW'(DIV - 1));

  always_ff @(posedge I_CLK_24M or negedge I_RSTn) begin
    if (!I_RSTn) tick_cnt <= '0;
    else         tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
  end

  // Stage 1: scale and mix
  logic signed [15:0] dig_sh, ana_sh, mix_sat;
  logic signed [17:0] mix18;

  assign dig_sh  = I_SND_DIG >>> DIG_SHIFT;
  assign ana_sh  = I_SND_ANA >>> ANA_SHIFT;
  assign mix18   = {{2{dig_sh[15]}}, dig_sh} + {{2{ana_sh[15]}}, ana_sh};
  assign mix_sat = sat16({{3{mix18[17]}}, mix18});

  // Stage 2: DC blocker y = m - x1 + y1 - (y1 >>> K)
  logic signed [15:0] s1_m, x1, y1, y1_sh, dcb_y;
  logic signed [19:0] dcb20;
  logic               s1_vld;

  assign y1_sh = y1 >>> DCB_K;
  assign dcb20 = {{4{s1_m[15]}}, s1_m} - {{4{x1[15]}}, x1}
               + {{4{y1[15]}}, y1}     - {{4{y1_sh[15]}}, y1_sh};
  assign dcb_y = sat16({dcb20[19], dcb20});

  // Stage 3: gain multiply (unity at 16, hence >>> 4)
  logic signed [15:0] s2_y, scaled;
  logic signed [20:0] prod;
  logic               s2_vld;
  logic        [4:0]  gain, gain_nxt, vol_c, target;

  assign prod   = $signed({{5{s2_y[15]}}, s2_y}) * $signed({16'd0, gain});
  assign scaled = sat16(prod >>> 4);

  assign vol_c  = (I_VOL > 5'd16) ? 5'd16 : I_VOL;
  assign target = I_MUTE ? 5'd0 : vol_c;

  always_comb begin
    gain_nxt = gain;
    if (gain < target)      gain_nxt = gain + 5'd1;
    else if (gain > target) gain_nxt = gain - 5'd1;
  end

  always_ff @(posedge I_CLK_24M or negedge I_RSTn) begin
    if (!I_RSTn) begin
      s1_vld    <= 1'b0;
      s1_m      <= '0;
      s2_vld    <= 1'b0;
      s2_y      <= '0;
      x1        <= '0;
      y1        <= '0;
      O_SND_OUT <= '0;
      O_SND_STB <= 1'b0;
      gain      <= '0;
      O_MUTED   <= 1'b1;
    end else begin
      s1_vld <= tick;
      if (tick) s1_m <= mix_sat;

      s2_vld <= s1_vld;
      if (s1_vld) begin
        x1 <= s1_m;
        if (I_DCB_EN) begin
          s2_y <= dcb_y;
          y1   <= dcb_y;
        end else begin
          // Bypass keeps the history clean so re-enabling starts from a zero state.
          s2_y <= s1_m;
          y1   <= '0;
        end
      end

      O_SND_STB <= s2_vld;
      if (s2_vld) begin
        // Gain steps after it has been used for this sample.
        O_SND_OUT <= scaled;
        gain      <= gain_nxt;
        O_MUTED   <= (gain_nxt == 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_mario_sound_mixer.sv
// tb_mario_sound_mixer
//   Scoreboard bench for mario_sound_mixer. The stimulus process pushes the expected
//   output of each upcoming strobe into a queue; a monitor pops and compares on every
//   O_SND_STB and also checks the strobe period.
module tb_mario_sound_mixer;

  localparam int DIV = 100;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] dig, ana;
  logic        [4:0]  vol;
  logic               mute, dcb_en;
  logic signed [15:0] snd_out;
  logic               snd_stb, muted;

  always #5 clk = ~clk;

  mario_sound_mixer #(
    .DIV       (DIV),
    .DIG_SHIFT (0),
    .ANA_SHIFT (0),
    .DCB_K     (8)
  ) dut (
    .I_CLK_24M (clk),
    .I_RSTn    (rst_n),
    .I_SND_DIG (dig),
    .I_SND_ANA (ana),
    .I_VOL     (vol),
    .I_MUTE    (mute),
    .I_DCB_EN  (dcb_en),
    .O_SND_OUT (snd_out),
    .O_SND_STB (snd_stb),
    .O_MUTED   (muted)
  );

  typedef struct {
    int    out;
    bit    muted;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   fails     = 0;
  int   n_strobes = 0;
  int   want      = 0;
  int   cyc       = 0;
  int   prev_cyc  = -1;

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_cyc = -1;
      end else if (snd_stb) begin
        n_strobes++;
        if (prev_cyc >= 0) begin
          checks++;
          if (cyc - prev_cyc != DIV) begin
            fails++;
            $display("FAIL strobe_period: got %0d clocks, expected %0d", cyc - prev_cyc, DIV);
          end
        end
        prev_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe: got out=%0d, expected no strobe", snd_out);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (int'(snd_out) != e.out) begin
            fails++;
            $display("FAIL %s out: got %0d, expected %0d", e.tag, snd_out, e.out);
          end
          checks++;
          if (muted != e.muted) begin
            fails++;
            $display("FAIL %s muted: got %0d, expected %0d", e.tag, muted, e.muted);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input int got, input int expv);
    checks++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  task automatic push_exp(input int o, input bit m, input string tag);
    exp_t e;
    e.out   = o;
    e.muted = m;
    e.tag   = tag;
    exp_q.push_back(e);
    want++;
  endtask

  task automatic wait_strobe();
    for (int i = 0; i < 3 * DIV && n_strobes < want; i++) @(posedge clk);
    #1;
    if (n_strobes < want) begin
      checks++;
      fails++;
      $display("FAIL strobe_timeout: got %0d strobes, expected %0d", n_strobes, want);
      exp_q.delete();
      want = n_strobes;
    end
  endtask

  task automatic exp_strobe(input int o, input bit m, input string tag);
    push_exp(o, m, tag);
    wait_strobe();
  endtask

  // Release reset on a falling edge and count rising edges to the first strobe.
  task automatic reset_release_check(input string tag);
    int first_edge;
    first_edge = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 3 * DIV; e++) begin
      @(posedge clk);
      #1;
      if (snd_stb) begin
        first_edge = e;
        break;
      end
    end
    check({tag, "_first_stb_edge"}, first_edge, DIV + 2);
    wait_strobe();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"},   int'(snd_out), 0);
    check({tag, "_stb"},   int'(snd_stb), 0);
    check({tag, "_muted"}, int'(muted),   1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int y;
    rst_n  = 1'b0;
    dig    = 16'sd1000;
    ana    = 16'sd0;
    vol    = 5'd16;
    mute   = 1'b0;
    dcb_en = 1'b0;

    // Reset state and first strobe timing
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    push_exp(0, 1'b0, "ramp_k1");
    reset_release_check("rel1");

    // Ramp-in 0 -> 16
    for (int k = 2; k <= 17; k++)
      exp_strobe((1000 * (k - 1)) >>> 4, 1'b0, $sformatf("ramp_k%0d", k));
    exp_strobe(1000, 1'b0, "ramp_hold");

    // Saturation (volume above 16 clamps to unity)
    dig = 16'sd30000;  ana = 16'sd10000;  vol = 5'd31;
    exp_strobe(32767, 1'b0, "sat_pos");
    dig = -16'sd30000; ana = -16'sd10000;
    exp_strobe(-32768, 1'b0, "sat_neg");

    // Mute ramp-down and release
    dig = 16'sd1600; ana = 16'sd0; vol = 5'd16;
    exp_strobe(1600, 1'b0, "mute_pre");
    mute = 1'b1;
    for (int j = 0; j <= 16; j++)
      exp_strobe(1600 - 100 * j, j >= 15, $sformatf("mute_%0d", j));
    mute = 1'b0;
    exp_strobe(0,   1'b0, "unmute_0");
    exp_strobe(100, 1'b0, "unmute_1");
    exp_strobe(200, 1'b0, "unmute_2");

    // Retarget mid-ramp: gain 3 steps down to 2 and holds
    vol = 5'd2;
    exp_strobe(300, 1'b0, "retarget_0");
    exp_strobe(200, 1'b0, "retarget_1");
    exp_strobe(200, 1'b0, "retarget_2");

    // Settle to unity gain on silence
    dig = 16'sd0; vol = 5'd16;
    for (int j = 0; j < 15; j++) exp_strobe(0, 1'b0, $sformatf("settle_%0d", j));

    // DC blocker step response: y[n+1] = y[n] - (y[n] >>> 8)
    dcb_en = 1'b1; dig = 16'sd8000;
    y = 8000;
    for (int n = 0; n <= 256; n++) begin
      exp_strobe(y, 1'b0, $sformatf("dcb_%0d", n));
      y = y - (y >>> 8);
    end
    dcb_en = 1'b0;
    exp_strobe(8000, 1'b0, "dcb_off");

    // Async reset at start, ramp to strobe 8, then async reset with a sample in flight
    dig = 16'sd1000;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst2");
    repeat (3) @(posedge clk);
    push_exp(0, 1'b0, "rst2_k1");
    reset_release_check("rel2");
    for (int k = 2; k <= 8; k++)
      exp_strobe((1000 * (k - 1)) >>> 4, 1'b0, $sformatf("rst2_k%0d", k));
    repeat (DIV - 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst3");
    repeat (3) @(posedge clk);
    push_exp(0, 1'b0, "rst3_k1");
    reset_release_check("rel3");
    exp_strobe(62,  1'b0, "rst3_k2");
    exp_strobe(125, 1'b0, "rst3_k3");

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
